fft_lane_rotator: RTL and testbench
===================================

// Module: fft_lane_rotator
// PURPOSE
//  Parametrised, registered successor of the FFT interface lane permuter. Selects one of two
//  N_LANE-wide sources (IOBUF / FSC feedback), cyclically rotates lanes by a static or
//  per-beat auto-advancing amount (conflict-free bank access), registers result behind a
//  valid/ready handshake with frame (SOF/EOF) tracking. Sits between IO buffer/FSC and PE array.
// PARAMETERS
//  N_LANE    16  lane count, power of 2, >=2; LW = log2(N_LANE)
//  DW        64  bits per lane (complex sample)
//  FRAME_LEN 16  beats per frame, >=1; EOF flagged on beat FRAME_LEN-1
//  ROT_STEP  1   auto-mode rotation increment per beat, taken mod N_LANE
// PORTS
//  CLK        in   1          clock, all state on rising edge
//  RSTN       in   1          asynchronous active-low reset
//  SEL_ITR    in   1          0: D_IOBUF, 1: D_FSC; sampled with accepted beat
//  ROT_MODE   in   1          0: static (rot = SEL_PERMR), 1: auto-advance
//  ROT_DIR    in   1          0: Q[i]=D[(i+rot)%N], 1: Q[i]=D[(i-rot)%N]
//  SEL_PERMR  in   LW         static rotation / auto-mode base at SOF
//  IN_VALID   in   1          input beat valid
//  IN_SOF     in   1          first beat of frame, qualified by IN_VALID
//  IN_READY   out  1          input beat accepted when IN_VALID&IN_READY
//  D_IOBUF    in   N_LANE*DW  lane i at [i*DW +: DW]
//  D_FSC      in   N_LANE*DW  lane i at [i*DW +: DW]
//  OUT_VALID  out  1          Q holds valid beat
//  OUT_READY  in   1          downstream accepts when OUT_VALID&OUT_READY
//  Q          out  N_LANE*DW  rotated lanes, same packing
//  OUT_SOF    out  1          beat is frame beat 0
//  OUT_EOF    out  1          beat is frame beat FRAME_LEN-1
//  OUT_ROT    out  LW         rotation applied to this beat
//  ERR_SOF    out  1          1-cycle pulse: protocol error (see below)
// BEHAVIOUR
//  Reset (async, RSTN=0): OUT_VALID=0, Q=0, OUT_SOF=OUT_EOF=0, OUT_ROT=0, ERR_SOF=0,
//   rot_cnt=0, beat_cnt=0, state=IDLE; held beat discarded immediately, mid-frame included.
//  Handshake: single output register; IN_READY = !OUT_VALID | OUT_READY (comb.). Accept ->
//   Q/flags load next edge (latency 1). No accept & OUT_READY & OUT_VALID -> OUT_VALID=0.
//   While OUT_VALID & !OUT_READY: Q, OUT_* stable. Simultaneous drain+accept: no bubble.
//  Rotation (per accepted beat): rot = SOF ? SEL_PERMR : (ROT_MODE ? rot_cnt : SEL_PERMR).
//   After accept: rot_cnt <= (rot + ROT_STEP) mod N_LANE (LW-bit wrap). ROT_DIR per beat.
//  FSM IDLE / IN_FRAME, beat_cnt (clog2(FRAME_LEN) bits, min 1):
//   IDLE + accept SOF -> beat 0 (OUT_SOF=1); FRAME_LEN=1 -> OUT_EOF=1 too, stay IDLE; else IN_FRAME.
//   IN_FRAME + accept !SOF -> beat_cnt+1; on FRAME_LEN-1 OUT_EOF=1, -> IDLE.
//   IN_FRAME + accept SOF -> ERR_SOF pulse, frame restarts at beat 0 with base SEL_PERMR.
//   IDLE + accept !SOF -> ERR_SOF pulse; beat passed with rot per rule above, OUT_SOF=OUT_EOF=0,
//    state/beat_cnt unchanged.
//  ERR_SOF asserts the cycle after the offending accept, independent of OUT_READY.
//  SEL_ITR, ROT_MODE, ROT_DIR, SEL_PERMR only sampled on accept; changes between beats harmless.
// TESTING (N_LANE=16, DW=64, FRAME_LEN=4, ROT_STEP=1; lane i of source = i, FSC = 100+i)
//  1 static, SEL_PERMR=3, DIR=0, SOF beat -> next cycle OUT_VALID=1, Q lane0=3, lane13=0,
//    lane15=2, OUT_ROT=3, OUT_SOF=1; SEL_ITR=1 same beat -> lane0=103.
//  2 DIR=1, SEL_PERMR=3 -> Q lane0=13, lane3=0; SEL_PERMR=0 -> identity either direction.
//  3 auto, base 2, 4 back-to-back beats -> OUT_ROT 2,3,4,5, OUT_EOF on 4th; next frame base 15
//    -> 15,0,1,2 (wrap), OUT_SOF only on first beat of each frame.
//  4 OUT_READY low 3 cycles mid-frame -> IN_READY=0, Q/OUT_ROT frozen, no beat lost or
//    duplicated; OUT_READY high -> stream resumes, sequence continues 1/cycle.
//  5 SOF on beat 2 of frame -> ERR_SOF 1 cycle, OUT_SOF=1, OUT_ROT=SEL_PERMR, EOF 3 beats later;
//    !SOF beat in IDLE -> ERR_SOF pulse, beat delivered.
//  6 RSTN low mid-frame with OUT_VALID=1 -> OUT_VALID=0, Q=0 without clock edge; after release
//    new SOF frame starts from base, beat 0.

Source files
------------

// File: rtl/fft_lane_rotator.sv
// Registered FFT lane rotator: selects IOBUF or FSC lanes, rotates them cyclically
// (static or auto-advancing per beat) and presents one beat behind a valid/ready register.
module fft_lane_rotator #(
  parameter int N_LANE    = 16,
  parameter int DW        = 64,
  parameter int FRAME_LEN = 16,
  parameter int ROT_STEP  = 1
) (
  input  logic                        CLK,
  input  logic                        RSTN,
  input  logic                        SEL_ITR,
  input  logic                        ROT_MODE,
  input  logic                        ROT_DIR,
  input  logic [$clog2(N_LANE)-1:0]   SEL_PERMR,
  input  logic                        IN_VALID,
  input  logic                        IN_SOF,
  output logic                        IN_READY,
  input  logic [N_LANE*DW-1:0]        D_IOBUF,
  input  logic [N_LANE*DW-1:0]        D_FSC,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic [N_LANE*DW-1:0]        Q,
  output logic                        OUT_SOF,
  output logic                        OUT_EOF,
  output logic [$clog2(N_LANE)-1:0]   OUT_ROT,
  output logic                        ERR_SOF
);

  localparam int LW = $clog2(N_LANE);
  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [LW-1:0] STEP = LW'(ROT_STEP % N_LANE);
  localparam logic [BW-1:0] LAST = BW'(FRAME_LEN - 1);

  typedef enum logic {S_IDLE, S_IN_FRAME} state_t;

  state_t                r_state;
  logic [BW-1:0]         r_beat_cnt;
  logic [LW-1:0]         r_rot_cnt;
  logic                  r_out_valid;
  logic [N_LANE*DW-1:0]  r_q;
  logic                  r_sof;
  logic                  r_eof;
  logic [LW-1:0]         r_rot;
  logic                  r_err;

  logic                  w_accept;
  logic [LW-1:0]         w_rot;
  logic [BW-1:0]         w_beat_nxt;
  logic [N_LANE*DW-1:0]  w_src;
  logic [N_LANE*DW-1:0]  w_rot_data;

  assign IN_READY   = ~r_out_valid | OUT_READY;
  assign w_accept   = IN_VALID & IN_READY;
  // A SOF beat always re-bases the rotation, even in auto mode.
  assign w_rot      = (IN_SOF | ~ROT_MODE) ? SEL_PERMR : r_rot_cnt;
  assign w_beat_nxt = r_beat_cnt + BW'(1);
  assign w_src      = SEL_ITR ? D_FSC : D_IOBUF;

  // Lane indices wrap naturally in LW bits because N_LANE is a power of two.
  for (genvar g = 0; g < N_LANE; g++) begin : g_lane
    logic [LW-1:0] w_idx;
    assign w_idx = ROT_DIR ? (LW'(g) - w_rot) : (LW'(g) + w_rot);
    assign w_rot_data[g*DW +: DW] = w_src[w_idx*DW +: DW];
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state     <= S_IDLE;
      r_beat_cnt  <= '0;
      r_rot_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_q         <= '0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_rot       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_q         <= w_rot_data;
        r_rot       <= w_rot;
        r_rot_cnt   <= w_rot + STEP;
        if (IN_SOF) begin
          r_err      <= (r_state == S_IN_FRAME);
          r_beat_cnt <= '0;
          r_sof      <= 1'b1;
          if (FRAME_LEN == 1) begin
            r_eof   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_eof   <= 1'b0;
            r_state <= S_IN_FRAME;
          end
        end else if (r_state == S_IN_FRAME) begin
          r_beat_cnt <= w_beat_nxt;
          r_sof      <= 1'b0;
          r_eof      <= (w_beat_nxt == LAST);
          if (w_beat_nxt == LAST) r_state <= S_IDLE;
        end else begin
          // Orphan beat outside a frame: flagged but still delivered.
          r_err <= 1'b1;
          r_sof <= 1'b0;
          r_eof <= 1'b0;
        end
      end else if (OUT_READY) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign OUT_VALID = r_out_valid;
  assign Q         = r_q;
  assign OUT_SOF   = r_sof;
  assign OUT_EOF   = r_eof;
  assign OUT_ROT   = r_rot;
  assign ERR_SOF   = r_err;

endmodule

// File: tb/tb_fft_lane_rotator.sv
// Bench for fft_lane_rotator: directed vector table, hand sequences for backpressure,
// protocol errors and async reset, then random traffic against a lane-array model.
module tb_fft_lane_rotator;

  localparam int N  = 16;
  localparam int DW = 64;
  localparam int FL = 4;
  localparam int RS = 1;

  logic            CLK = 1'b0;
  logic            RSTN;
  logic            SEL_ITR, ROT_MODE, ROT_DIR, IN_VALID, IN_SOF, OUT_READY;
  logic [3:0]      SEL_PERMR;
  logic            IN_READY, OUT_VALID, OUT_SOF, OUT_EOF, ERR_SOF;
  logic [N*DW-1:0] D_IOBUF, D_FSC, Q;
  logic [3:0]      OUT_ROT;

  fft_lane_rotator #(.N_LANE(N), .DW(DW), .FRAME_LEN(FL), .ROT_STEP(RS)) dut (
    .CLK(CLK), .RSTN(RSTN), .SEL_ITR(SEL_ITR), .ROT_MODE(ROT_MODE), .ROT_DIR(ROT_DIR),
    .SEL_PERMR(SEL_PERMR), .IN_VALID(IN_VALID), .IN_SOF(IN_SOF), .IN_READY(IN_READY),
    .D_IOBUF(D_IOBUF), .D_FSC(D_FSC), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .Q(Q), .OUT_SOF(OUT_SOF), .OUT_EOF(OUT_EOF), .OUT_ROT(OUT_ROT), .ERR_SOF(ERR_SOF)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  logic [63:0] d_io [N];
  logic [63:0] d_fsc[N];

  logic        m_valid, m_sof, m_eof, m_err, m_inframe;
  logic [3:0]  m_rot;
  int          m_beat, m_rotcnt;
  logic [63:0] m_q[N];

  typedef struct {
    int v, sof, itr, mode, dir, permr;
    int ovld, lane0, lidx, lval, rot, osof, oeof, oerr;
  } vec_t;
  vec_t tbl[13];

  function automatic vec_t mk(input int v, sof, itr, mode, dir, permr,
                              input int ovld, lane0, lidx, lval, rot, osof, oeof, oerr);
    vec_t t;
    t.v = v; t.sof = sof; t.itr = itr; t.mode = mode; t.dir = dir; t.permr = permr;
    t.ovld = ovld; t.lane0 = lane0; t.lidx = lidx; t.lval = lval; t.rot = rot;
    t.osof = osof; t.oeof = oeof; t.oerr = oerr;
    return t;
  endfunction

  task automatic chk_b(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_q(input string nm);
    int bad;
    bad = -1;
    for (int i = 0; i < N; i++)
      if (bad < 0 && Q[i*DW +: DW] !== m_q[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s lane%0d actual=%0h required=%0h", nm, bad, Q[bad*DW +: DW], m_q[bad]);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_sof = 1'b0; m_eof = 1'b0; m_err = 1'b0; m_inframe = 1'b0;
    m_rot = '0; m_beat = 0; m_rotcnt = 0;
    for (int i = 0; i < N; i++) m_q[i] = '0;
  endtask

  task automatic compare_model();
    chk_b("out_valid", OUT_VALID, m_valid);
    chk_b("err_sof", ERR_SOF, m_err);
    if (m_valid) begin
      chk_q("q");
      chk_b("out_sof", OUT_SOF, m_sof);
      chk_b("out_eof", OUT_EOF, m_eof);
      chk_w("out_rot", 64'(OUT_ROT), 64'(m_rot));
    end
  endtask

  // One clock: drive inputs, check ready, clock, advance model, compare outputs.
  task automatic step(input int v, sof, itr, mode, dir, permr, ordy);
    logic exp_rdy, acc;
    int   rot, src;
    IN_VALID = 1'(v); IN_SOF = 1'(sof); SEL_ITR = 1'(itr); ROT_MODE = 1'(mode);
    ROT_DIR = 1'(dir); SEL_PERMR = 4'(permr); OUT_READY = 1'(ordy);
    for (int i = 0; i < N; i++) begin
      D_IOBUF[i*DW +: DW] = d_io[i];
      D_FSC[i*DW +: DW]   = d_fsc[i];
    end
    #1;
    exp_rdy = !m_valid || (ordy != 0);
    chk_b("in_ready", IN_READY, exp_rdy);
    acc = (v != 0) && exp_rdy;
    @(posedge CLK);
    if (acc) begin
      rot = (sof != 0 || mode == 0) ? permr : m_rotcnt;
      m_rotcnt = (rot + RS) % N;
      m_rot = 4'(rot);
      for (int i = 0; i < N; i++) begin
        src = (dir != 0) ? (i - rot + N) % N : (i + rot) % N;
        m_q[i] = (itr != 0) ? d_fsc[src] : d_io[src];
      end
      m_valid = 1'b1;
      if (sof != 0) begin
        m_err = m_inframe;
        m_beat = 0;
        m_sof = 1'b1;
        m_eof = (FL == 1);
        m_inframe = (FL > 1);
      end else if (m_inframe) begin
        m_err = 1'b0;
        m_beat = m_beat + 1;
        m_sof = 1'b0;
        m_eof = (m_beat == FL - 1);
        if (m_beat == FL - 1) m_inframe = 1'b0;
      end else begin
        m_err = 1'b1;
        m_sof = 1'b0;
        m_eof = 1'b0;
      end
    end else begin
      m_err = 1'b0;
      if (ordy != 0) m_valid = 1'b0;
    end
    #1;
    compare_model();
  endtask

  initial begin
    int v, sof, itr, mode, dir, permr, ordy;
    RSTN = 1'b0; IN_VALID = 1'b0; IN_SOF = 1'b0; SEL_ITR = 1'b0; ROT_MODE = 1'b0;
    ROT_DIR = 1'b0; SEL_PERMR = '0; OUT_READY = 1'b0; D_IOBUF = '0; D_FSC = '0;
    for (int i = 0; i < N; i++) begin
      d_io[i]  = 64'(i);
      d_fsc[i] = 64'(100 + i);
    end
    model_reset();
    #12;
    chk_b("rst_out_valid", OUT_VALID, 1'b0);
    chk_w("rst_q_lane0", Q[63:0], 64'd0);
    chk_q("rst_q");
    chk_b("rst_out_sof", OUT_SOF, 1'b0);
    chk_b("rst_out_eof", OUT_EOF, 1'b0);
    chk_w("rst_out_rot", 64'(OUT_ROT), 64'd0);
    chk_b("rst_err_sof", ERR_SOF, 1'b0);
    chk_b("rst_in_ready", IN_READY, 1'b1);
    RSTN = 1'b1;
    @(posedge CLK); #1;

    // Directed table: static/dir/source cases, then two auto-mode frames (base 2, base 15).
    tbl[0]  = mk(1,1,0,0,0,3,   1,3,13,0,3,1,0,0);
    tbl[1]  = mk(1,0,1,0,0,3,   1,103,15,102,3,0,0,0);
    tbl[2]  = mk(1,0,0,0,1,3,   1,13,3,0,3,0,0,0);
    tbl[3]  = mk(1,0,0,0,1,0,   1,0,5,5,0,0,1,0);
    tbl[4]  = mk(1,1,0,1,0,2,   1,2,15,1,2,1,0,0);
    tbl[5]  = mk(1,0,0,1,0,9,   1,3,13,0,3,0,0,0);
    tbl[6]  = mk(1,0,0,1,0,9,   1,4,12,0,4,0,0,0);
    tbl[7]  = mk(1,0,0,1,0,9,   1,5,11,0,5,0,1,0);
    tbl[8]  = mk(1,1,0,1,0,15,  1,15,1,0,15,1,0,0);
    tbl[9]  = mk(1,0,0,1,0,15,  1,0,15,15,0,0,0,0);
    tbl[10] = mk(1,0,0,1,0,15,  1,1,15,0,1,0,0,0);
    tbl[11] = mk(1,0,0,1,0,15,  1,2,14,0,2,0,1,0);
    tbl[12] = mk(0,0,0,0,0,0,   0,0,0,0,0,0,0,0);
    for (int k = 0; k < 13; k++) begin
      step(tbl[k].v, tbl[k].sof, tbl[k].itr, tbl[k].mode, tbl[k].dir, tbl[k].permr, 1);
      chk_b($sformatf("tbl%0d_valid", k), OUT_VALID, 1'(tbl[k].ovld));
      if (tbl[k].ovld != 0) begin
        chk_w($sformatf("tbl%0d_lane0", k), Q[63:0], 64'(tbl[k].lane0));
        chk_w($sformatf("tbl%0d_lane%0d", k, tbl[k].lidx), Q[tbl[k].lidx*DW +: DW], 64'(tbl[k].lval));
        chk_w($sformatf("tbl%0d_rot", k), 64'(OUT_ROT), 64'(tbl[k].rot));
        chk_b($sformatf("tbl%0d_sof", k), OUT_SOF, 1'(tbl[k].osof));
        chk_b($sformatf("tbl%0d_eof", k), OUT_EOF, 1'(tbl[k].oeof));
        chk_b($sformatf("tbl%0d_err", k), ERR_SOF, 1'(tbl[k].oerr));
      end
    end

    // SOF arriving mid-frame restarts the frame; a non-SOF beat in IDLE is flagged.
    step(1,1,0,0,0,5,1);
    step(1,0,0,0,0,5,1);
    step(1,1,0,0,0,7,1);
    chk_b("err_midframe", ERR_SOF, 1'b1);
    chk_b("err_restart_sof", OUT_SOF, 1'b1);
    chk_w("err_restart_rot", 64'(OUT_ROT), 64'd7);
    step(1,0,0,0,0,7,1);
    chk_b("err_pulse_len", ERR_SOF, 1'b0);
    step(1,0,0,0,0,7,1);
    chk_b("err_eof_early", OUT_EOF, 1'b0);
    step(1,0,0,0,0,7,1);
    chk_b("err_eof", OUT_EOF, 1'b1);
    step(1,0,0,0,0,4,1);
    chk_b("err_idle_beat", ERR_SOF, 1'b1);
    chk_b("err_idle_valid", OUT_VALID, 1'b1);
    chk_b("err_idle_sof", OUT_SOF, 1'b0);
    step(0,0,0,0,0,0,1);

    // Backpressure: beat 1 waits three cycles behind a stalled beat 0.
    step(1,1,0,1,0,0,1);
    for (int k = 0; k < 3; k++) begin
      step(1,0,0,1,0,0,0);
      chk_b("bp_in_ready", IN_READY, 1'b0);
      chk_w("bp_rot_frozen", 64'(OUT_ROT), 64'd0);
    end
    step(1,0,0,1,0,0,1);
    chk_w("bp_resume_rot", 64'(OUT_ROT), 64'd1);
    step(1,0,0,1,0,0,1);
    step(1,0,0,1,0,0,1);
    chk_b("bp_eof", OUT_EOF, 1'b1);
    chk_w("bp_eof_rot", 64'(OUT_ROT), 64'd3);

    // Asynchronous reset mid-frame, between clock edges.
    step(1,1,0,1,0,4,1);
    step(1,0,0,1,0,4,1);
    #2;
    RSTN = 1'b0;
    IN_VALID = 1'b0;
    #1;
    model_reset();
    chk_b("arst_out_valid", OUT_VALID, 1'b0);
    chk_q("arst_q");
    chk_w("arst_rot", 64'(OUT_ROT), 64'd0);
    @(posedge CLK); #1;
    RSTN = 1'b1;
    step(1,1,0,1,0,6,1);
    chk_b("arst_new_sof", OUT_SOF, 1'b1);
    chk_w("arst_new_rot", 64'(OUT_ROT), 64'd6);
    step(1,0,0,1,0,6,1);
    step(1,0,0,1,0,6,1);
    step(1,0,0,1,0,6,1);
    chk_b("arst_new_eof", OUT_EOF, 1'b1);

    // Random traffic with random data, control fields and downstream stalls.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        d_io[i]  = {$urandom, $urandom};
        d_fsc[i] = {$urandom, $urandom};
      end
      v     = int'($urandom_range(0, 3) != 0);
      sof   = int'($urandom_range(0, 4) == 0);
      itr   = int'($urandom_range(0, 1));
      mode  = int'($urandom_range(0, 3) != 0);
      dir   = int'($urandom_range(0, 1));
      permr = int'($urandom_range(0, 15));
      ordy  = int'($urandom_range(0, 3) != 0);
      step(v, sof, itr, mode, dir, permr, ordy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
